// File: rtl/cache_pkg.sv
// Shared constants and state encoding for the cache controller and the line store.
package cache_pkg;

    localparam int unsigned LINE_WORDS = 4;
    localparam int unsigned TAG_W      = 22;
    localparam int unsigned TAG_LSB    = 10;
    localparam int unsigned INDEX_LSB  = 4;
    localparam int unsigned WORD_LSB   = 2;
    localparam int unsigned INDEX_W    = TAG_LSB - INDEX_LSB;
    localparam int unsigned WORD_W     = INDEX_LSB - WORD_LSB;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BACK = 2'd1,
        S_FILL = 2'd2,
        S_WAIT = 2'd3
    } state_e;

endpackage

// File: rtl/cache.sv
// Direct-mapped line store: combinational lookup, synchronous store/edit/invalidate.
module cache
    import cache_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      addr,
    input  logic [31:0]      din,
    input  logic             store,
    input  logic             edit,
    input  logic             invalid,
    output logic             hit,
    output logic             valid,
    output logic             dirty,
    output logic [31:0]      dout,
    output logic [TAG_W-1:0] tag
);

    localparam int unsigned LINES = 1 << INDEX_W;
    localparam int unsigned SLOTS = LINES * LINE_WORDS;

    logic [31:0]      data_q [SLOTS];
    logic [TAG_W-1:0] tag_q  [LINES];
    logic [LINES-1:0] valid_q;
    logic [LINES-1:0] dirty_q;

    logic [INDEX_W-1:0]        idx;
    logic [INDEX_W+WORD_W-1:0] slot;
    logic                      unused_byte_bits;

    assign idx  = addr[TAG_LSB-1:INDEX_LSB];
    assign slot = addr[TAG_LSB-1:WORD_LSB];
    assign unused_byte_bits = ^addr[WORD_LSB-1:0];

    assign valid = valid_q[idx];
    assign dirty = dirty_q[idx];
    assign tag   = tag_q[idx];
    assign dout  = data_q[slot];
    assign hit   = valid_q[idx] && (tag_q[idx] == addr[31:TAG_LSB]);

    // Data and tags need no reset; valid/dirty below gate their use.
    always_ff @(posedge clk) begin
        if (store || edit) begin
            data_q[slot] <= din;
        end
        if (store) begin
            tag_q[idx] <= addr[31:TAG_LSB];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
            dirty_q <= '0;
        end else begin
            if (store) begin
                valid_q[idx] <= 1'b1;
                dirty_q[idx] <= 1'b0;
            end else if (edit) begin
                dirty_q[idx] <= 1'b1;
            end
            if (invalid) begin
                valid_q[idx] <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/cache_ctrl.sv
// Blocking cache controller: serves hits combinationally, runs write-back/refill on a miss.
module cache_ctrl #(
    parameter int unsigned LINE_WORDS = cache_pkg::LINE_WORDS,
    parameter int unsigned TAG_W      = cache_pkg::TAG_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cpu_en_r,
    input  logic             cpu_en_w,
    input  logic [31:0]      cpu_addr,
    input  logic [31:0]      cpu_din,
    output logic [31:0]      cpu_dout,
    output logic             cpu_stall,
    output logic [31:0]      c_addr,
    output logic [31:0]      c_din,
    output logic             c_store,
    output logic             c_edit,
    output logic             c_invalid,
    input  logic             c_hit,
    input  logic             c_valid,
    input  logic             c_dirty,
    input  logic [31:0]      c_dout,
    input  logic [TAG_W-1:0] c_tag,
    output logic             mem_cs,
    output logic             mem_we,
    output logic [31:0]      mem_addr,
    output logic [31:0]      mem_din,
    input  logic [31:0]      mem_dout,
    input  logic             mem_ack
);
    import cache_pkg::*;

    localparam int unsigned CNT_W = $clog2(LINE_WORDS);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LINE_WORDS - 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]      req_addr_q, req_addr_d;
    logic [TAG_W-1:0] victim_tag_q, victim_tag_d;

    logic        req;
    logic [31:0] back_addr;
    logic [31:0] fill_addr;
    logic        unused_req_low;

    assign req       = cpu_en_r | cpu_en_w;
    assign back_addr = {victim_tag_q, req_addr_q[TAG_LSB-1:INDEX_LSB], cnt_q, {WORD_LSB{1'b0}}};
    assign fill_addr = {req_addr_q[31:INDEX_LSB], cnt_q, {WORD_LSB{1'b0}}};
    assign unused_req_low = ^req_addr_q[INDEX_LSB-1:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            req_addr_q   <= '0;
            victim_tag_q <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            req_addr_q   <= req_addr_d;
            victim_tag_q <= victim_tag_d;
        end
    end

    // Next state and the combinational cache/memory/CPU outputs.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        req_addr_d   = req_addr_q;
        victim_tag_d = victim_tag_q;
        cpu_dout     = '0;
        cpu_stall    = 1'b0;
        c_addr       = '0;
        c_din        = '0;
        c_store      = 1'b0;
        c_edit       = 1'b0;
        c_invalid    = 1'b0;
        mem_cs       = 1'b0;
        mem_we       = 1'b0;
        mem_addr     = '0;
        mem_din      = '0;

        case (state_q)
            S_IDLE: begin
                c_addr = cpu_addr;
                if (req && c_hit) begin
                    if (cpu_en_w) begin
                        c_edit = 1'b1;
                        c_din  = cpu_din;
                    end else begin
                        cpu_dout = c_dout;
                    end
                end else if (req) begin
                    cpu_stall    = 1'b1;
                    req_addr_d   = cpu_addr;
                    victim_tag_d = c_tag;
                    cnt_d        = '0;
                    state_d      = (c_valid && c_dirty) ? S_BACK : S_FILL;
                end
            end
            S_BACK: begin
                cpu_stall = 1'b1;
                c_addr    = back_addr;
                mem_cs    = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = back_addr;
                mem_din   = c_dout;
                if (mem_ack) begin
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_LAST) begin
                        state_d = S_FILL;
                    end
                end
            end
            S_FILL: begin
                cpu_stall = 1'b1;
                c_addr    = fill_addr;
                mem_cs    = 1'b1;
                mem_addr  = fill_addr;
                if (mem_ack) begin
                    c_store = 1'b1;
                    c_din   = mem_dout;
                    cnt_d   = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_LAST) begin
                        state_d = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                cpu_stall = 1'b1;
                state_d   = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Reset silences every output, including the combinational hit path.
        if (rst) begin
            cpu_dout  = '0;
            cpu_stall = 1'b0;
            c_addr    = '0;
            c_din     = '0;
            c_store   = 1'b0;
            c_edit    = 1'b0;
            mem_cs    = 1'b0;
            mem_we    = 1'b0;
            mem_addr  = '0;
            mem_din   = '0;
        end
    end

endmodule
